// File: rtl/draw_sequencer.sv
// -----------------------------------------------------------------------------
// draw_sequencer
//
// Sequences the number draws of the bingo game. On a manual 'next' pulse or an
// automatic timer expiry it takes a candidate from the hack input or the PRNG.
// Illegal BCD values, the 00 marker and already-drawn numbers are rejected.
// For PRNG candidates the generator is stepped and re-sampled, up to MAX_RETRY
// candidates per trigger. An accepted number is offered to game_logic with a
// valid/ack handshake. The bookkeeping of drawn numbers and turns is updated
// only when game_logic acknowledges the draw.
//
// Ports
//   clk, rst     : clock, synchronous active-high reset
//   start_game   : game enable level; low returns to IDLE and clears history
//   endgame      : BINGO reached, stops further draws (READY -> DONE)
//   next         : one-cycle manual draw request (honoured only in READY)
//   auto_en      : enable timed automatic draws every AUTO_PERIOD cycles
//   load_hack    : candidate source select (1 = hack_number, 0 = prng_number)
//   hack_number  : BCD hack value
//   prng_number  : current PRNG output
//   draw_ack     : game_logic accepted draw_number
//   prng_step    : one-cycle pulse asking the PRNG to advance
//   draw_valid   : draw_number is valid, held until draw_ack
//   draw_number  : accepted BCD number
//   reject       : one-cycle pulse, trigger ended without a draw
//   busy         : a trigger is being processed or a draw is outstanding
//   turn_count   : accepted draws in this game (0..99)
//   all_drawn    : every number 01..99 has been drawn
// -----------------------------------------------------------------------------
module draw_sequencer #(
    parameter int AUTO_PERIOD = 100_000_000,
    parameter int MAX_RETRY   = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_game,
    input  logic       endgame,
    input  logic       next,
    input  logic       auto_en,
    input  logic       load_hack,
    input  logic [7:0] hack_number,
    input  logic [7:0] prng_number,
    input  logic       draw_ack,
    output logic       prng_step,
    output logic       draw_valid,
    output logic [7:0] draw_number,
    output logic       reject,
    output logic       busy,
    output logic [6:0] turn_count,
    output logic       all_drawn
);

    localparam int TW = $clog2(AUTO_PERIOD);
    localparam int RW = (MAX_RETRY > 1) ? $clog2(MAX_RETRY) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(AUTO_PERIOD - 1);
    localparam logic [TW-1:0] TIMER_ONE  = 1;
    localparam logic [RW-1:0] RETRY_LAST = RW'(MAX_RETRY - 1);
    localparam logic [RW-1:0] RETRY_ONE  = 1;

    typedef enum logic [2:0] {
        IDLE, READY, SAMPLE, CHECK, REROLL, ISSUE, DONE
    } state_t;

    state_t          state_reg, state_next;
    logic [7:0]      cand_reg;
    logic            src_hack_reg;
    logic [RW-1:0]   retry_reg;
    logic [TW-1:0]   timer_reg;
    logic [99:0]     used_reg;
    logic [99:0]     used_set;
    logic [6:0]      turn_count_reg;
    logic            all_drawn_reg;
    logic [7:0]      draw_number_reg;

    logic [6:0]      cand_idx;
    logic            digits_ok;
    logic            cand_invalid;
    logic            timer_hit;
    logic            trigger;
    logic            reject_pulse;
    logic            record_draw;
    logic            last_draw;

    // Decimal index 0..99 of the BCD candidate; only meaningful when both
    // digits are legal, which cand_invalid accounts for.
    assign cand_idx     = 7'(cand_reg[7:4]) * 7'd10 + 7'(cand_reg[3:0]);
    assign digits_ok    = (cand_reg[7:4] <= 4'd9) && (cand_reg[3:0] <= 4'd9);
    assign cand_invalid = !digits_ok || (cand_reg == 8'h00) || used_reg[cand_idx];

    assign timer_hit    = auto_en && (timer_reg == TIMER_LAST);
    assign record_draw  = (state_reg == ISSUE) && draw_ack && start_game;
    assign last_draw    = (turn_count_reg == 7'd98);

    // One-hot set mask for the history bit of the number being acknowledged.
    generate
        for (genvar gi = 0; gi < 100; gi++) begin : g_used_set
            assign used_set[gi] = record_draw && (cand_idx == 7'(gi));
        end
    endgenerate

    always_comb begin
        state_next   = state_reg;
        trigger      = 1'b0;
        reject_pulse = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start_game) state_next = READY;
            end
            READY: begin
                // endgame wins over a simultaneous trigger
                if (endgame) begin
                    state_next = DONE;
                end else if (next || timer_hit) begin
                    trigger    = 1'b1;
                    state_next = SAMPLE;
                end
            end
            SAMPLE: state_next = CHECK;
            CHECK: begin
                if (!cand_invalid) begin
                    state_next = ISSUE;
                end else if (src_hack_reg || (retry_reg == RETRY_LAST)) begin
                    reject_pulse = 1'b1;
                    state_next   = READY;
                end else begin
                    state_next = REROLL;
                end
            end
            REROLL: state_next = SAMPLE;
            ISSUE: begin
                if (draw_ack) state_next = last_draw ? DONE : READY;
            end
            DONE:    state_next = DONE;
            default: state_next = IDLE;
        endcase
        // Dropping start_game aborts whatever is in progress.
        if (!start_game) begin
            state_next   = IDLE;
            trigger      = 1'b0;
            reject_pulse = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= IDLE;
            cand_reg        <= '0;
            src_hack_reg    <= 1'b0;
            retry_reg       <= '0;
            timer_reg       <= '0;
            used_reg        <= '0;
            turn_count_reg  <= '0;
            all_drawn_reg   <= 1'b0;
            draw_number_reg <= '0;
        end else begin
            state_reg <= state_next;

            // The auto timer only runs while resting in READY.
            if ((state_reg == READY) && (state_next == READY) && auto_en)
                timer_reg <= timer_reg + TIMER_ONE;
            else
                timer_reg <= '0;

            if (trigger)
                retry_reg <= '0;
            else if (state_reg == REROLL)
                retry_reg <= retry_reg + RETRY_ONE;

            if (state_reg == SAMPLE) begin
                cand_reg     <= load_hack ? hack_number : prng_number;
                src_hack_reg <= load_hack;
            end

            if ((state_reg == CHECK) && (state_next == ISSUE))
                draw_number_reg <= cand_reg;

            if (!start_game) begin
                used_reg       <= '0;
                turn_count_reg <= '0;
                all_drawn_reg  <= 1'b0;
            end else if (record_draw) begin
                used_reg       <= used_reg | used_set;
                turn_count_reg <= turn_count_reg + 7'd1;
                if (last_draw) all_drawn_reg <= 1'b1;
            end
        end
    end

    // REROLL always lasts exactly one cycle, so this is a single pulse.
    assign prng_step   = (state_reg == REROLL);
    assign draw_valid  = (state_reg == ISSUE);
    assign draw_number = draw_number_reg;
    assign reject      = reject_pulse;
    assign busy        = (state_reg == SAMPLE) || (state_reg == CHECK) ||
                         (state_reg == REROLL) || (state_reg == ISSUE);
    assign turn_count  = turn_count_reg;
    assign all_drawn   = all_drawn_reg;

endmodule
